// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared state encoding, opcode constants and field widths for the phase sequencer
package seq_pkg;

    localparam int OPC_W  = 5;
    localparam int WAIT_W = 4;

    localparam logic [OPC_W-1:0] OP_STP = 5'b00000;
    localparam logic [OPC_W-1:0] OP_MLR = 5'b01001;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FE    = 3'd1,
        ST_E1    = 3'd2,
        ST_MULW  = 3'd3,
        ST_E2    = 3'd4,
`ifdef SEQ_SINGLE_STEP_EN
        ST_PAUSE = 3'd6,
`endif
        ST_HALT  = 3'd5
    } seq_state_t;

endpackage

// File: rtl/seq_wait_counter.sv
// rtl/seq_wait_counter.sv - loadable down-counter timing the multiplier wait state
module seq_wait_counter
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [WAIT_W-1:0] value,
    output logic              zero
);

    logic [WAIT_W-1:0] count_q;

    // Saturates at zero so an idle counter never wraps back into a wait.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= value;
        end else if (count_q != '0) begin
            count_q <= count_q - WAIT_W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/cpu_phase_sequencer.sv
// rtl/cpu_phase_sequencer.sv - fe/e1/e2 phase sequencer with mlr wait, stp halt and retire counter; SEQ_SINGLE_STEP_EN adds single-step
module cpu_phase_sequencer
    import seq_pkg::*;
#(
    parameter int MUL_LAT = 2,
    parameter int ICNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [OPC_W-1:0]  opcode,
    input  logic              extra1,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic              step_mode,
    input  logic              step,
`endif
    output logic              fe,
    output logic              e1,
    output logic              e2,
    output logic              mul_start,
    output logic              halted,
    output logic              busy,
    output logic [ICNT_W-1:0] icnt
);

    localparam logic [WAIT_W-1:0] WAIT_INIT = (MUL_LAT > 0) ? WAIT_W'(MUL_LAT - 1) : '0;

    seq_state_t        state_q;
    seq_state_t        state_d;
    seq_state_t        retire_state;
    logic              retire;
    logic              wait_load;
    logic              wait_zero;
    logic [ICNT_W-1:0] icnt_q;
    logic              is_mlr;

    assign is_mlr = (opcode == OP_MLR) && extra1;

    seq_wait_counter u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (wait_load),
        .value (WAIT_INIT),
        .zero  (wait_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            icnt_q  <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                icnt_q <= icnt_q + ICNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_load = 1'b0;
        retire    = 1'b0;
`ifdef SEQ_SINGLE_STEP_EN
        retire_state = step_mode ? ST_PAUSE : ST_FE;
`else
        retire_state = ST_FE;
`endif
        case (state_q)
            ST_IDLE: if (run) state_d = ST_FE;
            ST_FE:   state_d = ST_E1;
            ST_E1: begin
                if (opcode == OP_STP) begin
                    state_d = ST_HALT;
                end else if (is_mlr && (MUL_LAT > 0)) begin
                    state_d   = ST_MULW;
                    wait_load = 1'b1;
                end else if (extra1) begin
                    state_d = ST_E2;
                end else begin
                    state_d = retire_state;
                    retire  = 1'b1;
                end
            end
            ST_MULW: if (wait_zero) state_d = ST_E2;
            ST_E2: begin
                state_d = retire_state;
                retire  = 1'b1;
            end
            ST_HALT: state_d = ST_HALT;
`ifdef SEQ_SINGLE_STEP_EN
            ST_PAUSE: if (step || !step_mode) state_d = ST_FE;
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    assign fe        = (state_q == ST_FE);
    assign e1        = (state_q == ST_E1);
    assign e2        = (state_q == ST_E2);
    assign mul_start = e1 && is_mlr;
    assign halted    = (state_q == ST_HALT);
    assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
    assign icnt      = icnt_q;

endmodule
